pwm_sine_sequencer: RTL and testbench

Sequencer for the PWM sine datapath. It owns the PWM period counter and the active compare width, and drives the `pwm` output. Once per PWM period it advances a phase accumulator and fetches the next duty sample from an external sine table over a req/ack handshake. The fetched sample is double-buffered, so the compare width changes only on a period boundary and `pwm` never glitches.

---
 rtl/pwm_sine_sequencer.sv | 108 ++++++++++
 tb/tb_pwm_sine_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sine_sequencer.sv
// PWM sine sequencer: owns the PWM period counter and active compare width,
// and fetches one double-buffered duty sample per period over a req/ack handshake.
module pwm_sine_sequencer #(
  parameter int unsigned PERIOD  = 1000,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WIDTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_step,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_ack,
  input  logic [WIDTH_W-1:0] rom_data,
  output logic [WIDTH_W-1:0] width,
  output logic               tick,
  output logic               pwm,
  output logic               underrun
);

  localparam logic [WIDTH_W-1:0] PERIOD_V = WIDTH_W'(PERIOD);
  localparam logic [WIDTH_W-1:0] LAST_V   = WIDTH_W'(PERIOD - 1);

  typedef enum logic [2:0] {IDLE, PRIME, FETCH, HOLD, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [WIDTH_W-1:0]  counter;
  logic [WIDTH_W-1:0]  shadow;
  logic [WIDTH_W-1:0]  sample;
  logic [PHASE_W-1:0]  phase;
  logic                running;
  logic                ack;

  always_comb begin
    running = (state == FETCH) || (state == HOLD);
    tick    = (counter == LAST_V);
    ack     = rom_ack && rom_req;
    sample  = (rom_data > PERIOD_V) ? PERIOD_V : rom_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (enable) state_nxt = PRIME;
      PRIME: if (ack) state_nxt = enable ? FETCH : IDLE;
      FETCH: begin
        // a disable at the boundary wins over a same-cycle ack or underrun
        if (tick && !enable) state_nxt = ack ? IDLE : DRAIN;
        else if (ack)        state_nxt = HOLD;
      end
      HOLD:  if (tick) state_nxt = enable ? FETCH : IDLE;
      DRAIN: if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      phase    <= '0;
      width    <= '0;
      shadow   <= '0;
      underrun <= 1'b0;
    end else begin
      counter <= (running && !tick) ? counter + 1'b1 : '0;
      unique case (state)
        IDLE: if (enable) begin
          underrun <= 1'b0;
          phase    <= '0;
        end
        PRIME: if (ack && enable) begin
          width <= sample;
          phase <= phase + phase_step;
        end
        FETCH: begin
          if (ack) shadow <= sample;
          if (tick) begin
            if (enable) underrun <= 1'b1;
            else        width    <= '0;
          end
        end
        HOLD: if (tick) begin
          if (enable) begin
            width <= shadow;
            phase <= phase + phase_step;
          end else begin
            width <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_req  = (state == PRIME) || (state == FETCH) || (state == DRAIN);
    rom_addr = phase[PHASE_W-1 -: ADDR_W];
    pwm      = running && (counter < width);
  end

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// Bench for pwm_sine_sequencer: period-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_sine_sequencer;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] phase_step;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = '0;
  logic [7:0]  width;
  logic        tick;
  logic        pwm;
  logic        underrun;

  pwm_sine_sequencer #(.PERIOD(P), .PHASE_W(16), .ADDR_W(8), .WIDTH_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_step(phase_step),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .width(width), .tick(tick), .pwm(pwm), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ROM responder: ack after ack_delay cycles of rom_req high
  int ack_delay = 0;
  int data_mode = 0;
  int cdata = 0;
  int age = 0;

  function automatic logic [7:0] resp_data(input logic [7:0] a);
    case (data_mode)
      0:       return 8'(int'(a) % 11);
      1:       return 8'(cdata);
      default: return 8'(int'(a) + 5);
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    rom_ack = 1'b0;
    if (rst) age = 0;
    else if (rom_req) begin
      if (age >= ack_delay) begin
        rom_ack  = 1'b1;
        rom_data = resp_data(rom_addr);
        age = 0;
      end else age++;
    end else age = 0;
  end

  // Reference model: period position, active width, outstanding request kind
  bit m_active, m_req, m_have, m_under;
  int m_t, m_width, m_samp, m_phase, m_mode;  // mode 0 prime, 1 fetch, 2 discard
  bit mk_tick, mk_ack, mk_had;
  int mk_smp;

  always @(posedge clk) begin
    mk_tick = m_active && (m_t == P - 1);
    mk_ack  = rom_ack && m_req;
    mk_smp  = (int'(rom_data) > P) ? P : int'(rom_data);
    mk_had  = m_have;
    if (rst) begin
      m_active = 0; m_req = 0; m_have = 0; m_under = 0;
      m_t = 0; m_width = 0; m_samp = 0; m_phase = 0; m_mode = 0;
    end else if (!m_active && !m_req) begin
      if (enable) begin
        m_under = 0; m_phase = 0; m_req = 1; m_mode = 0;
      end
    end else begin
      if (m_active) m_t = mk_tick ? 0 : m_t + 1;
      if (mk_ack) begin
        m_req = 0;
        if (m_mode == 0 && enable) begin
          m_width = mk_smp; m_phase = (m_phase + int'(phase_step)) % 65536;
          m_active = 1; m_t = 0; m_req = 1; m_mode = 1;
        end else if (m_mode == 1) begin
          m_have = 1; m_samp = mk_smp;
        end
      end
      if (mk_tick) begin
        if (!enable) begin
          m_active = 0; m_width = 0; m_have = 0; m_t = 0; m_mode = 2;
        end else if (mk_had) begin
          m_width = m_samp; m_have = 0;
          m_phase = (m_phase + int'(phase_step)) % 65536;
          m_req = 1; m_mode = 1;
        end else begin
          m_under = 1;
        end
      end
    end
  end

  int hi_cnt = 0;
  int hi_q[$];
  int addr_q[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("rom_req", rom_req, m_req);
      check("rom_addr", rom_addr, 32'((m_phase >> 8) & 255));
      check("tick", tick, m_active && (m_t == P - 1));
      check("pwm", pwm, m_active && (m_t < m_width));
      check("width", width, m_width);
      check("underrun", underrun, m_under);
      if (pwm) hi_cnt++;
      if (tick) begin
        hi_q.push_back(hi_cnt);
        hi_cnt = 0;
      end
      if (rom_req && rom_ack) addr_q.push_back(int'(rom_addr));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack();
    int n = 0;
    @(negedge clk);
    while (!(rom_req && rom_ack) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    cycles(2);
    rst = 1'b0;
    hi_q.delete(); addr_q.delete(); hi_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; phase_step = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    cycles(1);

    // Reset mid-FETCH with a request outstanding
    rst = 1'b0;
    cycles(3);
    check("idle_no_req", rom_req, 0);
    ack_delay = 3; data_mode = 0; enable = 1'b1;
    wait_ack();
    cycles(1);
    check("fetch_req", rom_req, 1);
    check("fetch_addr", rom_addr, 1);
    rst = 1'b1;
    cycles(1);
    check("rst_req", rom_req, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_width", width, 0);
    check("rst_pwm", pwm, 0);
    check("rst_tick", tick, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0; enable = 1'b0;
    cycles(3);
    check("post_rst_req", rom_req, 0);

    // Sequencing: addr k gives data k, so period k has pwm high k cycles
    do_reset();
    ack_delay = 2; data_mode = 0; phase_step = 16'h0100; enable = 1'b1;
    cycles(75);
    check("seq_periods", (hi_q.size() >= 6), 1);
    check("seq_reqs", (addr_q.size() >= 6), 1);
    for (int i = 0; i < 6; i++) begin
      if (i < hi_q.size()) check("seq_high", hi_q[i], i);
      if (i < addr_q.size()) check("seq_addr", addr_q[i], i);
    end

    // Clamp and extremes
    do_reset();
    ack_delay = 2; data_mode = 1; cdata = 15; enable = 1'b1;
    cycles(35);
    check("clamp_width", width, 10);
    check("clamp_periods", (hi_q.size() >= 2), 1);
    if (hi_q.size() > 0) check("clamp_high", hi_q[$], 10);
    cdata = 0;
    cycles(40);
    check("zero_width", width, 0);
    if (hi_q.size() > 0) check("zero_high", hi_q[$], 0);

    // Phase wrap with zero-latency acks
    do_reset();
    ack_delay = 0; data_mode = 0; phase_step = 16'hFF00; enable = 1'b1;
    cycles(50);
    check("wrap_reqs", (addr_q.size() >= 4), 1);
    if (addr_q.size() >= 4) begin
      check("wrap_addr0", addr_q[0], 8'h00);
      check("wrap_addr1", addr_q[1], 8'hFF);
      check("wrap_addr2", addr_q[2], 8'hFE);
      check("wrap_addr3", addr_q[3], 8'hFD);
    end

    // Underrun, then disable with a request outstanding, then re-enable
    do_reset();
    ack_delay = 25; data_mode = 2; phase_step = 16'h0100; enable = 1'b1;
    wait_ack();
    cycles(11);
    check("ur_flag", underrun, 1);
    check("ur_width_held", width, 5);
    cycles(18);
    check("ur_width_still", width, 5);
    cycles(2);
    check("ur_applied", width, 6);
    check("ur_next_req", rom_req, 1);
    check("ur_next_addr", rom_addr, 2);
    check("ur_one_req", addr_q.size(), 2);
    enable = 1'b0;
    cycles(10);
    check("dis_pwm", pwm, 0);
    check("dis_width", width, 0);
    check("dis_req_held", rom_req, 1);
    check("dis_addr_held", rom_addr, 2);
    cycles(16);
    check("drain_done", rom_req, 0);
    ack_delay = 1; enable = 1'b1;
    cycles(1);
    check("reen_underrun", underrun, 0);
    check("reen_req", rom_req, 1);
    check("reen_addr", rom_addr, 0);
    check("reen_reqs", addr_q.size(), 3);
    cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
